// File: rtl/peripheral_interrupt_controller_pkg.sv
// Shared source-mode codes and width helper for the peripheral interrupt controller.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package peripheral_interrupt_controller_pkg;

  // Per-bit source mode codes; 2'b11 is treated the same as strobe.
  localparam logic [1:0] IMODE_RO     = 2'b00;
  localparam logic [1:0] IMODE_STROBE = 2'b01;
  localparam logic [1:0] IMODE_EDGE   = 2'b10;

  // Ceiling log2 with a floor of 1, so a single-bank or single-bit index still has a port bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/peripheral_interrupt_controller_if.sv
// Register access bus for the PIR/PIE banks: bank select, write strobes, data, readback.
// Latency: writes take effect at the next clock edge; readback is combinational on addr.
// Backpressure: none, every write is accepted in the cycle it is presented.
interface peripheral_interrupt_controller_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 1
);
  logic [AW-1:0]    addr;
  logic             pir_wr_en;
  logic             pie_wr_en;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] pir_q;
  logic [WIDTH-1:0] pie_q;

  modport master (output addr, pir_wr_en, pie_wr_en, d, input pir_q, pie_q);
  modport slave  (input addr, pir_wr_en, pie_wr_en, d, output pir_q, pie_q);
endinterface

// File: rtl/interrupt_source_cond.sv
// Per-bit source conditioner: optional synchroniser, edge history, flag-set pulse and level out.
// Latency: SYNC_STAGES cycles from src to level/set_pulse (0 = combinational).
// Backpressure: none, the source is sampled every cycle.
module interrupt_source_cond
  import peripheral_interrupt_controller_pkg::*;
#(
  parameter logic [1:0] MODE        = IMODE_STROBE,
  parameter int         SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  output logic set_pulse,
  output logic level
);

  logic s;
  logic prev_q;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      // Shift the raw source through the synchroniser chain.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= src;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
      assign s = src;
    end
  endgenerate

  // Previous-cycle source; resets to 0 so a source already high at reset release counts as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= s;
  end

  // Decide whether this cycle sets the stored flag.
  always_comb begin
    set_pulse = 1'b0;
    case (MODE)
      IMODE_RO:           set_pulse = 1'b0;
      IMODE_EDGE:         set_pulse = s & ~prev_q;
      IMODE_STROBE, 2'b11: set_pulse = s;
      default:            set_pulse = s;
    endcase
  end

  assign level = s;

endmodule

// File: rtl/peripheral_interrupt_controller.sv
// Banked PIR/PIE flag and enable registers with a priority-encoded, registered peripheral IRQ.
// Latency: flag set at edge N -> irq/irq_id/irq_valid update after edge N+1; readback combinational.
// Backpressure: none, register writes and source events are absorbed every cycle.
module peripheral_interrupt_controller
  import peripheral_interrupt_controller_pkg::*;
#(
  parameter int                               WIDTH       = 8,
  parameter int                               NUM_REGS    = 2,
  parameter logic [2*NUM_REGS*WIDTH-1:0]      BIT_MODE    = {NUM_REGS*WIDTH{2'b01}},
  parameter logic [NUM_REGS*WIDTH-1:0]        RESET_PIR   = '0,
  parameter logic [NUM_REGS*WIDTH-1:0]        RESET_PIE   = '0,
  parameter int                               SYNC_STAGES = 0,
  localparam int                              NB          = NUM_REGS * WIDTH,
  localparam int                              AW          = clog2(NUM_REGS),
  localparam int                              IDW         = clog2(NUM_REGS * WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  peripheral_interrupt_controller_if.slave bus,
  input  logic [NB-1:0]                 src,
  input  logic                          peie,
  output logic                          irq,
  output logic [IDW-1:0]                irq_id,
  output logic                          irq_valid
);

  logic [NB-1:0]       set_vec;
  logic [NB-1:0]       level_vec;
  logic [NB-1:0]       ro_mask;
  logic [NB-1:0]       flag_q, flag_d;
  logic [NB-1:0]       pie_q, pie_d;
  logic [NB-1:0]       view;
  logic [NB-1:0]       pend;
  logic [NUM_REGS-1:0] bank_hit;
  logic [WIDTH-1:0]    pir_rd, pie_rd;
  logic [IDW-1:0]      enc;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_src
      interrupt_source_cond #(
        .MODE        (BIT_MODE[2*gi +: 2]),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_cond (
        .clk       (clk),
        .rst_n     (rst_n),
        .src       (src[gi]),
        .set_pulse (set_vec[gi]),
        .level     (level_vec[gi])
      );
      assign ro_mask[gi] = (BIT_MODE[2*gi +: 2] == IMODE_RO);
    end
  endgenerate

  // Bank decode; an out-of-range address hits no bank, so reads give 0 and writes are dropped.
  always_comb begin
    bank_hit = '0;
    for (int b = 0; b < NUM_REGS; b++) bank_hit[b] = (bus.addr == AW'(b));
  end

  // Next flag/enable state: software write first, then hardware set overrides to 1.
  always_comb begin
    flag_d = flag_q;
    pie_d  = pie_q;
    for (int b = 0; b < NUM_REGS; b++) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (bus.pir_wr_en && bank_hit[b]) flag_d[b*WIDTH + k] = bus.d[k];
        if (bus.pie_wr_en && bank_hit[b]) pie_d[b*WIDTH + k]  = bus.d[k];
      end
    end
    // Readonly bits have no storage; keep their flop at 0.
    flag_d = (flag_d | set_vec) & ~ro_mask;
  end

  // Flag and enable storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= RESET_PIR;
      pie_q  <= RESET_PIE;
    end else begin
      flag_q <= flag_d;
      pie_q  <= pie_d;
    end
  end

  // Visible PIR contents: readonly bits show the conditioned source level.
  assign view = (flag_q & ~ro_mask) | (level_vec & ro_mask);
  assign pend = view & pie_q;

  // Readback muxes for the selected bank.
  always_comb begin
    pir_rd = '0;
    pie_rd = '0;
    for (int b = 0; b < NUM_REGS; b++) begin
      if (bank_hit[b]) begin
        pir_rd = pir_rd | view[b*WIDTH +: WIDTH];
        pie_rd = pie_rd | pie_q[b*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.pir_q = pir_rd;
  assign bus.pie_q = pie_rd;

  // Priority encoder: lowest flat index wins (bank0 bit0 highest priority).
  always_comb begin
    enc = '0;
    for (int j = NB - 1; j >= 0; j--) begin
      if (pend[j]) enc = IDW'(j);
    end
  end

  // Registered interrupt outputs; irq_valid ignores the global enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq       <= 1'b0;
      irq_id    <= '0;
      irq_valid <= 1'b0;
    end else begin
      irq       <= peie & (|pend);
      irq_id    <= enc;
      irq_valid <= |pend;
    end
  end

endmodule
